rc4_stream: RTL and testbench
=============================

RC4_STREAM -- requirements
Module: rc4_stream

Interface
REQ-001 SHALL have parameter SBOX_AW, default 6, S-box index width; S-box holds N=2^SBOX_AW entries of SBOX_AW bits.
REQ-002 SHALL have parameter KEY_MAX, default 32, maximum stored key bytes (power of two, at most 256).
REQ-003 SHALL have parameter DROP_N, default 64, keystream bytes discarded when RC4_DROP_EN is defined.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-006 SHALL have ports key_valid (input, 1) and key_in (input, 8): key byte stream, one byte per high cycle.
REQ-007 SHALL have ports din_valid (input, 1), din (input, 8), din_last (input, 1) and din_ready (output, 1): input data handshake.
REQ-008 SHALL have ports dout_valid (output, 1), dout (output, 8) and dout_ready (input, 1): output data handshake.
REQ-009 SHALL have ports busy (output, 1), high outside IDLE/STREAM, and msg_done (output, 1), a one-cycle pulse per message.

Function
REQ-010 SHALL implement states IDLE, LOAD_KEY, INIT, KSA, DROP, STREAM.
REQ-011 IDLE -> LOAD_KEY on key_valid; the first byte SHALL be stored in that cycle.
REQ-012 LOAD_KEY: stores each key_valid byte at key_len and increments key_len; bytes beyond KEY_MAX are ignored and key_len saturates; key_valid low -> INIT.
REQ-013 INIT SHALL last 1 cycle: S[x]=x for all x; i=j=kidx=0.
REQ-014 KSA SHALL run exactly N cycles: j=(j+S[i]+key[kidx]) mod N, swap S[i],S[j], i++, kidx=(kidx+1) mod key_len; key bytes are truncated to SBOX_AW bits.
REQ-015 After KSA, i=j=0; go to DROP if RC4_DROP_EN is defined, else to STREAM.
REQ-016 STREAM: din_ready SHALL equal (!dout_valid || dout_ready).
REQ-017 On a din handshake: i=i+1; j=j+S[i]; swap; dout=din XOR zero-extended S[(S[i]+S[j]) mod N] using post-swap values; dout_valid is set on the next edge (latency 1).
REQ-018 All index arithmetic SHALL wrap mod N; swaps with i==j SHALL leave S unchanged.
REQ-019 dout and dout_valid SHALL hold stable while dout_valid && !dout_ready.
REQ-020 Throughput SHALL be one byte per cycle with dout_ready held high.
REQ-021 A handshake with din_last=1 marks end of message; when that byte's dout handshake completes, msg_done SHALL pulse and the FSM SHALL enter INIT, re-running KSA with the stored key.
REQ-022 din_ready SHALL be 0 from the last-byte handshake until STREAM is re-entered.
REQ-023 key_valid in INIT, KSA, DROP or STREAM SHALL abort: clear dout_valid, key_len=0, store the byte, enter LOAD_KEY; no msg_done.
REQ-024 In IDLE, din_ready=0 and din is ignored.

Reset
REQ-025 rst SHALL force IDLE and clear key_len, i, j, kidx, dout_valid, dout, msg_done, busy and din_ready to 0; S-box and key contents are don't-care.
REQ-026 rst mid-KSA or mid-STREAM SHALL discard all state; the next key load restarts cleanly.

Configuration
REQ-027 Macro RC4_DROP_EN defined: the DROP state SHALL run DROP_N generation steps (REQ-017 without output), then enter STREAM; din_ready=0 and busy=1 during DROP.
REQ-028 Macro RC4_DROP_EN undefined: no DROP state or counter; KSA goes directly to STREAM.

Verification
REQ-029 SBOX_AW=8, no drop, key "Key", din "Plaintext", dout_ready=1 -> dout BB F3 16 E8 D9 40 AF 0A D3, one byte per cycle, msg_done after the 9th byte.
REQ-030 SBOX_AW=8, key "Wiki", din "pedia" -> 10 21 BF 04 20; a second identical message without rekey -> the same ciphertext.
REQ-031 SBOX_AW=8, key "Key", din all 0x00 for 10 bytes, random dout_ready -> EB 9F 77 81 B7 34 CA 72 A7 19 with no loss or duplication.
REQ-032 KEY_MAX=32, 40 key bytes -> key_len=32; output matches the model using the first 32 bytes.
REQ-033 key_valid pulsed mid-STREAM -> dout_valid=0 next cycle, no msg_done, and the new key's KSA matches the model.
REQ-034 RC4_DROP_EN, DROP_N=4, SBOX_AW=8, key "Key", din zeros -> first dout B7 34 CA 72.

Source files
------------

// File: rtl/rc4_stream.sv
// rc4_stream: RC4 stream cipher engine with a parameterised S-box width.
// A key is streamed in byte by byte and stored. The S-box is initialised
// and scrambled (KSA) from that key, and each accepted data byte is XORed
// with one keystream byte. After every message (din_last) the stored key is
// re-scheduled so that each message starts from a fresh keystream.
//
// Optional feature macro: RC4_DROP_EN. When defined, DROP_N keystream bytes
// are generated and discarded after every KSA before data is accepted.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   key_valid  in   key byte strobe (also aborts a running session)
//   key_in     in   key byte [7:0]
//   din_valid  in   input data valid
//   din        in   input data byte [7:0]
//   din_last   in   marks the last byte of a message
//   din_ready  out  input data ready
//   dout_valid out  output data valid
//   dout       out  output data byte [7:0]
//   dout_ready in   output data ready
//   busy       out  high outside IDLE / STREAM
//   msg_done   out  one-cycle pulse after the last output byte is taken
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no key stored; waits for the first key byte
// LOAD_KEY  | storing key bytes while key_valid is high
// INIT      | S[x] = x, i = j = kidx = 0 (one cycle)
// KSA       | N key-scheduling swaps, one per cycle
// DROP      | discards DROP_N keystream bytes (RC4_DROP_EN only)
// STREAM    | encrypts one byte per din handshake
module rc4_stream #(
   parameter int SBOX_AW = 6,
   parameter int KEY_MAX = 32,
   parameter int DROP_N  = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [7:0] key_in,
   input  logic       din_valid,
   input  logic [7:0] din,
   input  logic       din_last,
   output logic       din_ready,
   output logic       dout_valid,
   output logic [7:0] dout,
   input  logic       dout_ready,
   output logic       busy,
   output logic       msg_done
);

   localparam int N   = 1 << SBOX_AW;
   localparam int KAW = $clog2(KEY_MAX);

   localparam logic [SBOX_AW-1:0] IDX_ONE  = SBOX_AW'(1);
   localparam logic [SBOX_AW-1:0] IDX_LAST = '1;
   localparam logic [KAW:0]       KLEN_ONE = (KAW+1)'(1);
   localparam logic [KAW:0]       KLEN_MAX = (KAW+1)'(KEY_MAX);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD_KEY = 3'd1,
      ST_INIT     = 3'd2,
      ST_KSA      = 3'd3,
`ifdef RC4_DROP_EN
      ST_DROP     = 3'd4,
`endif
      ST_STREAM   = 3'd5
   } state_t;

   state_t state_q, state_d;

   logic [SBOX_AW-1:0] sbox_q [N];
   logic [SBOX_AW-1:0] key_q  [KEY_MAX];
   logic [KAW:0]       key_len_q;
   logic [KAW-1:0]     kidx_q;
   logic [SBOX_AW-1:0] i_q, j_q;
   logic               dout_valid_q;
   logic [7:0]         dout_q;
   logic               msg_done_q;
   logic               last_pend_q;

   logic abort, init_sbox, ksa_step, ksa_last, gen_step, din_hs, msg_fire;
   logic key_first, key_app, drop_done;
   logic din_ready_c, busy_c;

   // Only the low SBOX_AW bits of each key byte take part in the schedule.
   generate
      if (SBOX_AW < 8) begin : g_key_trunc
         logic [7-SBOX_AW:0] unused_key_hi;
         assign unused_key_hi = key_in[7:SBOX_AW];
      end
   endgenerate

   // KSA step
   logic [SBOX_AW-1:0] ksa_si, ksa_j, ksa_sj;
   logic [KAW:0]       kidx_inc;
   logic [KAW-1:0]     kidx_nxt;

   assign ksa_si   = sbox_q[i_q];
   assign ksa_j    = j_q + ksa_si + key_q[kidx_q];
   assign ksa_sj   = sbox_q[ksa_j];
   assign kidx_inc = {1'b0, kidx_q} + KLEN_ONE;
   assign kidx_nxt = (kidx_inc == key_len_q) ? '0 : kidx_inc[KAW-1:0];

   // Keystream generation step; the output lookup must see the post-swap
   // S-box, so the two just-swapped locations are forwarded.
   logic [SBOX_AW-1:0] gen_i, gen_j, gen_si, gen_sj, gen_t, gen_k;

   assign gen_i  = i_q + IDX_ONE;
   assign gen_si = sbox_q[gen_i];
   assign gen_j  = j_q + gen_si;
   assign gen_sj = sbox_q[gen_j];
   assign gen_t  = gen_si + gen_sj;
   assign gen_k  = (gen_t == gen_i) ? gen_sj :
                   (gen_t == gen_j) ? gen_si : sbox_q[gen_t];

`ifdef RC4_DROP_EN
   localparam int DCW = (DROP_N > 1) ? $clog2(DROP_N) : 1;
   logic [DCW-1:0] drop_cnt_q;

   assign drop_done = (drop_cnt_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_q <= '0;
      end else if (ksa_last) begin
         drop_cnt_q <= DCW'(DROP_N - 1);
      end else if (gen_step && (state_q == ST_DROP)) begin
         drop_cnt_q <= drop_cnt_q - DCW'(1);
      end
   end
`else
   localparam int unused_drop_n = DROP_N;
   assign drop_done = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (key_valid) state_d = ST_LOAD_KEY;
         ST_LOAD_KEY: if (!key_valid) state_d = ST_INIT;
         ST_INIT:     state_d = abort ? ST_LOAD_KEY : ST_KSA;
         ST_KSA: begin
            if (abort) state_d = ST_LOAD_KEY;
`ifdef RC4_DROP_EN
            else if (i_q == IDX_LAST) state_d = ST_DROP;
`else
            else if (i_q == IDX_LAST) state_d = ST_STREAM;
`endif
         end
`ifdef RC4_DROP_EN
         ST_DROP: begin
            if (abort)          state_d = ST_LOAD_KEY;
            else if (drop_done) state_d = ST_STREAM;
         end
`endif
         ST_STREAM: begin
            if (abort)         state_d = ST_LOAD_KEY;
            else if (msg_fire) state_d = ST_INIT;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      abort       = 1'b0;
      init_sbox   = 1'b0;
      ksa_step    = 1'b0;
      gen_step    = 1'b0;
      din_hs      = 1'b0;
      msg_fire    = 1'b0;
      din_ready_c = 1'b0;
      busy_c      = 1'b1;
      case (state_q)
         ST_IDLE: busy_c = 1'b0;
         ST_INIT: begin
            abort     = key_valid;
            init_sbox = !key_valid;
         end
         ST_KSA: begin
            abort    = key_valid;
            ksa_step = !key_valid;
         end
`ifdef RC4_DROP_EN
         ST_DROP: begin
            abort    = key_valid;
            gen_step = !key_valid;
         end
`endif
         ST_STREAM: begin
            busy_c      = 1'b0;
            abort       = key_valid;
            // Once the last byte is in, input stays closed until the next KSA.
            din_ready_c = !last_pend_q && (!dout_valid_q || dout_ready);
            din_hs      = din_valid && din_ready_c && !key_valid;
            gen_step    = din_hs;
            msg_fire    = !key_valid && last_pend_q && dout_valid_q && dout_ready;
         end
         default: ;
      endcase
   end

   assign ksa_last  = ksa_step && (i_q == IDX_LAST);
   assign key_first = key_valid && ((state_q == ST_IDLE) || abort);
   assign key_app   = key_valid && (state_q == ST_LOAD_KEY) && (key_len_q != KLEN_MAX);

   // Control datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         key_len_q    <= '0;
         kidx_q       <= '0;
         i_q          <= '0;
         j_q          <= '0;
         dout_valid_q <= 1'b0;
         dout_q       <= '0;
         msg_done_q   <= 1'b0;
         last_pend_q  <= 1'b0;
      end else begin
         msg_done_q <= msg_fire;

         if (key_first)    key_len_q <= KLEN_ONE;
         else if (key_app) key_len_q <= key_len_q + KLEN_ONE;

         if (init_sbox) begin
            i_q    <= '0;
            j_q    <= '0;
            kidx_q <= '0;
         end
         if (ksa_step) begin
            i_q    <= i_q + IDX_ONE;
            j_q    <= ksa_last ? '0 : ksa_j;
            kidx_q <= kidx_nxt;
         end
         if (gen_step) begin
            i_q <= gen_i;
            j_q <= gen_j;
         end

         if (abort) begin
            dout_valid_q <= 1'b0;
            last_pend_q  <= 1'b0;
         end else if (din_hs) begin
            dout_valid_q <= 1'b1;
            dout_q       <= din ^ 8'(gen_k);
            last_pend_q  <= din_last;
         end else begin
            if (dout_ready) dout_valid_q <= 1'b0;
            if (msg_fire)   last_pend_q  <= 1'b0;
         end
      end
   end

   // S-box and key storage; contents are meaningless until loaded/initialised.
   always_ff @(posedge clk) begin
      if (init_sbox) begin
         for (int x = 0; x < N; x++) sbox_q[x] <= SBOX_AW'(x);
      end else if (ksa_step) begin
         sbox_q[i_q]   <= ksa_sj;
         sbox_q[ksa_j] <= ksa_si;
      end else if (gen_step) begin
         sbox_q[gen_i] <= gen_sj;
         sbox_q[gen_j] <= gen_si;
      end

      if (key_first)    key_q[0]                    <= key_in[SBOX_AW-1:0];
      else if (key_app) key_q[key_len_q[KAW-1:0]]   <= key_in[SBOX_AW-1:0];
   end

   assign din_ready  = din_ready_c;
   assign busy       = busy_c;
   assign dout_valid = dout_valid_q;
   assign dout       = dout_q;
   assign msg_done   = msg_done_q;

endmodule

// File: tb/tb_rc4_stream.sv
// Directed bench for rc4_stream with SBOX_AW=8 (byte RC4), KEY_MAX=32,
// DROP_N=4. Known-answer vectors are constants; long-key, abort and reset
// scenarios use a plain software RC4 reference.
module tb_rc4_stream;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_valid;
   logic [7:0] key_in;
   logic       din_valid;
   logic [7:0] din;
   logic       din_last;
   logic       din_ready;
   logic       dout_valid;
   logic [7:0] dout;
   logic       dout_ready;
   logic       busy;
   logic       msg_done;

   always #5 clk = ~clk;

   rc4_stream #(.SBOX_AW(8), .KEY_MAX(32), .DROP_N(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_valid  (key_valid),
      .key_in     (key_in),
      .din_valid  (din_valid),
      .din        (din),
      .din_last   (din_last),
      .din_ready  (din_ready),
      .dout_valid (dout_valid),
      .dout       (dout),
      .dout_ready (dout_ready),
      .busy       (busy),
      .msg_done   (msg_done)
   );

   int n_vec = 0;
   int n_mis = 0;

   logic [7:0] key_bytes[$];
   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   int done_cnt, done_cyc, first_cyc, last_cyc, stall_err;

   int m_s[256];
   int m_i, m_j;

   // Reference RC4 (key truncated to 32 bytes, optional discard)
   task automatic model_ksa();
      int klen, j, t;
      klen = (key_bytes.size() > 32) ? 32 : key_bytes.size();
      for (int x = 0; x < 256; x++) m_s[x] = x;
      j = 0;
      for (int i = 0; i < 256; i++) begin
         j = (j + m_s[i] + int'(key_bytes[i % klen])) % 256;
         t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      end
      m_i = 0;
      m_j = 0;
`ifdef RC4_DROP_EN
      for (int d = 0; d < 4; d++) begin
         logic [7:0] junk;
         model_next(junk);
      end
`endif
   endtask

   task automatic model_next(output logic [7:0] ks);
      int t;
      m_i = (m_i + 1) % 256;
      m_j = (m_j + m_s[m_i]) % 256;
      t = m_s[m_i]; m_s[m_i] = m_s[m_j]; m_s[m_j] = t;
      ks = 8'(m_s[(m_s[m_i] + m_s[m_j]) % 256]);
   endtask

   task automatic model_expect();
      logic [7:0] ks;
      model_ksa();
      exp_q.delete();
      foreach (tx_q[k]) begin
         model_next(ks);
         exp_q.push_back(tx_q[k] ^ ks);
      end
   endtask

   // Stimulus drivers (start and end at a falling edge)
   task automatic load_key();
      foreach (key_bytes[k]) begin
         key_valid = 1'b1;
         key_in    = key_bytes[k];
         @(negedge clk);
      end
      key_valid = 1'b0;
   endtask

   task automatic run_msg(input bit rand_ready);
      int idx, cyc;
      bit prev_stall;
      logic [7:0] prev_dout;
      idx = 0; cyc = 0; prev_stall = 0; prev_dout = '0;
      rx_q.delete();
      done_cnt = 0; done_cyc = -1; first_cyc = -1; last_cyc = -1; stall_err = 0;
      while (cyc < 3000 && !(rx_q.size() >= tx_q.size() && done_cnt > 0)) begin
         dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (idx < tx_q.size()) begin
            din_valid = 1'b1;
            din       = tx_q[idx];
            din_last  = (idx == tx_q.size() - 1);
         end else begin
            din_valid = 1'b0;
            din_last  = 1'b0;
         end
         #1;
         if (msg_done) begin done_cnt++; done_cyc = cyc; end
         if (prev_stall && (dout_valid !== 1'b1 || dout !== prev_dout)) stall_err++;
         prev_stall = dout_valid && !dout_ready;
         prev_dout  = dout;
         if (dout_valid && dout_ready) begin
            rx_q.push_back(dout);
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
         end
         if (din_valid && din_ready) idx++;
         cyc++;
         @(negedge clk);
      end
      din_valid  = 1'b0;
      din_last   = 1'b0;
      dout_ready = 1'b1;
   endtask

   task automatic wait_din_ready(output int waited);
      waited = 0;
      #1;
      while (!din_ready && waited < 1000) begin
         @(negedge clk);
         #1;
         waited++;
      end
   endtask

   // Tests
   task automatic test_reset();
      rst = 1'b1; key_valid = 0; key_in = 0; din_valid = 0; din = 0; din_last = 0;
      dout_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      din_valid = 1'b1;
      din = 8'hAA;
      @(negedge clk); #1;
      n_vec++; if (dout_valid !== 1'b0) begin n_mis++; $display("FAIL reset dout_valid: got %b want 0", dout_valid); end
      n_vec++; if (dout !== 8'h00) begin n_mis++; $display("FAIL reset dout: got %h want 00", dout); end
      n_vec++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset busy: got %b want 0", busy); end
      n_vec++; if (msg_done !== 1'b0) begin n_mis++; $display("FAIL reset msg_done: got %b want 0", msg_done); end
      n_vec++; if (din_ready !== 1'b0) begin n_mis++; $display("FAIL reset din_ready: got %b want 0", din_ready); end
      repeat (3) @(negedge clk);
      #1;
      n_vec++; if (din_ready !== 1'b0 || dout_valid !== 1'b0) begin
         n_mis++; $display("FAIL idle ignores din: got ready=%b valid=%b want 0 0", din_ready, dout_valid);
      end
      din_valid = 1'b0;
      @(negedge clk);
   endtask

`ifndef RC4_DROP_EN
   task automatic test_plaintext();
      key_bytes = '{8'h4B, 8'h65, 8'h79};
      tx_q  = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
      exp_q = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
      load_key();
      #1;
      n_vec++; if (busy !== 1'b1) begin n_mis++; $display("FAIL plaintext busy after key: got %b want 1", busy); end
      run_msg(1'b0);
      foreach (exp_q[k]) begin
         logic [7:0] got;
         got = (k < rx_q.size()) ? rx_q[k] : 8'h00;
         n_vec++;
         if (k >= rx_q.size() || got !== exp_q[k]) begin
            n_mis++; $display("FAIL plaintext byte %0d: got %h want %h", k, got, exp_q[k]);
         end
      end
      n_vec++; if (last_cyc - first_cyc !== 8) begin n_mis++; $display("FAIL plaintext throughput span: got %0d want 8", last_cyc - first_cyc); end
      n_vec++; if (done_cnt !== 1) begin n_mis++; $display("FAIL plaintext msg_done count: got %0d want 1", done_cnt); end
      n_vec++; if (done_cyc !== last_cyc + 1) begin n_mis++; $display("FAIL plaintext msg_done timing: got %0d want %0d", done_cyc, last_cyc + 1); end
   endtask

   task automatic test_wiki_repeat();
      key_bytes = '{8'h57, 8'h69, 8'h6B, 8'h69};
      tx_q  = '{8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
      exp_q = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
      load_key();
      for (int m = 0; m < 2; m++) begin
         run_msg(1'b0);
         foreach (exp_q[k]) begin
            logic [7:0] got;
            got = (k < rx_q.size()) ? rx_q[k] : 8'h00;
            n_vec++;
            if (k >= rx_q.size() || got !== exp_q[k]) begin
               n_mis++; $display("FAIL wiki msg %0d byte %0d: got %h want %h", m, k, got, exp_q[k]);
            end
         end
         n_vec++; if (done_cnt !== 1) begin n_mis++; $display("FAIL wiki msg %0d msg_done count: got %0d want 1", m, done_cnt); end
      end
   endtask

   task automatic test_backpressure();
      key_bytes = '{8'h4B, 8'h65, 8'h79};
      tx_q  = '{10{8'h00}};
      exp_q = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
      load_key();
      run_msg(1'b1);
      n_vec++; if (rx_q.size() !== 10) begin n_mis++; $display("FAIL backpressure count: got %0d want 10", rx_q.size()); end
      foreach (exp_q[k]) begin
         logic [7:0] got;
         got = (k < rx_q.size()) ? rx_q[k] : 8'h00;
         n_vec++;
         if (k >= rx_q.size() || got !== exp_q[k]) begin
            n_mis++; $display("FAIL backpressure byte %0d: got %h want %h", k, got, exp_q[k]);
         end
      end
      n_vec++; if (stall_err !== 0) begin n_mis++; $display("FAIL backpressure hold: got %0d unstable stalls want 0", stall_err); end
      n_vec++; if (done_cnt !== 1) begin n_mis++; $display("FAIL backpressure msg_done count: got %0d want 1", done_cnt); end
   endtask
`else
   task automatic test_drop();
      key_bytes = '{8'h4B, 8'h65, 8'h79};
      tx_q  = '{4{8'h00}};
      exp_q = '{8'hB7, 8'h34, 8'hCA, 8'h72};
      load_key();
      run_msg(1'b0);
      foreach (exp_q[k]) begin
         logic [7:0] got;
         got = (k < rx_q.size()) ? rx_q[k] : 8'h00;
         n_vec++;
         if (k >= rx_q.size() || got !== exp_q[k]) begin
            n_mis++; $display("FAIL drop byte %0d: got %h want %h", k, got, exp_q[k]);
         end
      end
   endtask
`endif

   task automatic test_long_key();
      key_bytes.delete();
      for (int k = 0; k < 40; k++) key_bytes.push_back(8'(k * 13 + 5));
      tx_q.delete();
      for (int k = 0; k < 8; k++) tx_q.push_back(8'(k * 3));
      model_expect();
      load_key();
      run_msg(1'b0);
      foreach (exp_q[k]) begin
         logic [7:0] got;
         got = (k < rx_q.size()) ? rx_q[k] : 8'h00;
         n_vec++;
         if (k >= rx_q.size() || got !== exp_q[k]) begin
            n_mis++; $display("FAIL long_key byte %0d: got %h want %h", k, got, exp_q[k]);
         end
      end
   endtask

   task automatic test_abort();
      int waited;
      bit saw_done;
      key_bytes = '{8'h4B, 8'h65, 8'h79};
      load_key();
      dout_ready = 1'b0;
      din_valid  = 1'b1;
      din        = 8'h00;
      din_last   = 1'b0;
      wait_din_ready(waited);
      n_vec++; if (waited >= 1000) begin n_mis++; $display("FAIL abort wait din_ready: got timeout after %0d cycles want ready", waited); end
      @(negedge clk);
      din_valid = 1'b0;
      #1;
      n_vec++; if (dout_valid !== 1'b1) begin n_mis++; $display("FAIL abort held byte: got dout_valid=%b want 1", dout_valid); end
      key_bytes = '{8'h57, 8'h69, 8'h6B, 8'h69};
      key_valid = 1'b1;
      key_in    = key_bytes[0];
      @(negedge clk); #1;
      n_vec++; if (dout_valid !== 1'b0) begin n_mis++; $display("FAIL abort dout_valid: got %b want 0", dout_valid); end
      saw_done = msg_done;
      for (int k = 1; k < 4; k++) begin
         key_in = key_bytes[k];
         @(negedge clk); #1;
         saw_done = saw_done | msg_done;
      end
      n_vec++; if (saw_done !== 1'b0) begin n_mis++; $display("FAIL abort msg_done: got %b want 0", saw_done); end
      key_valid  = 1'b0;
      dout_ready = 1'b1;
      tx_q = '{8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
      model_expect();
      @(negedge clk);
      run_msg(1'b0);
      foreach (exp_q[k]) begin
         logic [7:0] got;
         got = (k < rx_q.size()) ? rx_q[k] : 8'h00;
         n_vec++;
         if (k >= rx_q.size() || got !== exp_q[k]) begin
            n_mis++; $display("FAIL abort rekey byte %0d: got %h want %h", k, got, exp_q[k]);
         end
      end
   endtask

   task automatic test_reset_mid_stream();
      int waited;
      key_bytes = '{8'h4B, 8'h65, 8'h79};
      load_key();
      dout_ready = 1'b1;
      din_valid  = 1'b1;
      din        = 8'h00;
      wait_din_ready(waited);
      n_vec++; if (waited >= 1000) begin n_mis++; $display("FAIL rst_mid wait din_ready: got timeout after %0d cycles want ready", waited); end
      repeat (3) @(negedge clk);
      rst       = 1'b1;
      din_valid = 1'b0;
      @(negedge clk); #1;
      n_vec++; if (dout_valid !== 1'b0 || din_ready !== 1'b0 || busy !== 1'b0 || dout !== 8'h00) begin
         n_mis++; $display("FAIL rst_mid outputs: got valid=%b ready=%b busy=%b dout=%h want 0 0 0 00",
                           dout_valid, din_ready, busy, dout);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      key_bytes = '{8'h57, 8'h69, 8'h6B, 8'h69};
      tx_q = '{8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
      model_expect();
      load_key();
      run_msg(1'b0);
      foreach (exp_q[k]) begin
         logic [7:0] got;
         got = (k < rx_q.size()) ? rx_q[k] : 8'h00;
         n_vec++;
         if (k >= rx_q.size() || got !== exp_q[k]) begin
            n_mis++; $display("FAIL rst_mid byte %0d: got %h want %h", k, got, exp_q[k]);
         end
      end
   endtask

   initial begin
      test_reset();
`ifndef RC4_DROP_EN
      test_plaintext();
      test_wiki_repeat();
      test_backpressure();
`else
      test_drop();
`endif
      test_long_key();
      test_abort();
      test_reset_mid_stream();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running want finished");
      $fatal(1, "watchdog expired");
   end

endmodule
